// File: rtl/fix_session_mgr_if.sv
// Purpose : Bundles the application, TOE and fifo-facing signals of the FIX session manager.
// Latency : n/a (signal container only).
// Backpressure: none; every signal is a pulse or a level.
// Ports   : master = app/TOE/fifo side (drives the *_i signals), slave = session manager (drives the *_o signals).
interface fix_session_mgr_if #(
  parameter int HOST_AW = 2
);
  logic               connect_i;
  logic [HOST_AW-1:0] connect_to_host_i;
  logic               disconnect_i;
  logic               connected_i;
  logic [HOST_AW-1:0] connected_host_addr_i;
  logic [7:0]         message_i;
  logic               valid_i;

  logic               connect_req_o;
  logic [HOST_AW-1:0] connect_addr_o;
  logic               disconnect_o;
  logic [HOST_AW-1:0] disconnect_host_num_o;
  logic               session_up_o;
  logic               connect_fail_o;
  logic               link_lost_o;
  logic               message_received_o;
  logic               checksum_err_o;

  modport master (
    output connect_i, connect_to_host_i, disconnect_i, connected_i,
           connected_host_addr_i, message_i, valid_i,
    input  connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
           session_up_o, connect_fail_o, link_lost_o, message_received_o,
           checksum_err_o
  );

  modport slave (
    input  connect_i, connect_to_host_i, disconnect_i, connected_i,
           connected_host_addr_i, message_i, valid_i,
    output connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
           session_up_o, connect_fail_o, link_lost_o, message_received_o,
           checksum_err_o
  );
endinterface

// File: rtl/fix_session_mgr.sv
// Purpose : FIX session manager: connect/retry/disconnect FSM toward the TOE plus a trailer
//           framer ("<SOH>10=ddd<SOH>") on the received byte stream while the session is up.
// Latency : all outputs registered; connect_req_o on the cycle after connect_i, message pulses
//           on the cycle after the final SOH is accepted.
// Backpressure: none; bytes are accepted whenever valid_i=1 in state UP, dropped otherwise.
// Ports   : clk, rst (synchronous, active-high), bus (fix_session_mgr_if.slave).
// Config  : define FIX_CHECKSUM_EN to verify the 3-digit checksum (8-bit wrapping byte sum);
//           without it checksum_err_o is tied low and every framed message is reported.
module fix_session_mgr #(
  parameter int HOST_AW     = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 3
) (
  input logic              clk,
  input logic              rst,
  fix_session_mgr_if.slave bus
);

  localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_UP,
    ST_DISC
  } state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [RW-1:0]      retry_cnt;
  logic [HOST_AW-1:0] addr;
  logic [HOST_AW-1:0] disc_host;
  logic               connect_req;
  logic               connect_fail;
  logic               link_lost;
  logic               disconnect;
  logic               session_up;

  // ---------------------------------------------------------------- session FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      retry_cnt    <= '0;
      addr         <= '0;
      disc_host    <= '0;
      connect_req  <= 1'b0;
      connect_fail <= 1'b0;
      link_lost    <= 1'b0;
      disconnect   <= 1'b0;
      session_up   <= 1'b0;
    end else begin
      connect_req  <= 1'b0;
      connect_fail <= 1'b0;
      link_lost    <= 1'b0;
      disconnect   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.connect_i) begin
            addr        <= bus.connect_to_host_i;
            retry_cnt   <= '0;
            connect_req <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          timer <= TW'(TIMEOUT_CYC);
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Ack is checked first so it wins over a coincident expiry. Expiring at
          // timer==1 makes one attempt exactly TIMEOUT_CYC+1 cycles (REQ + wait).
          if (bus.connected_i && (bus.connected_host_addr_i == addr)) begin
            session_up <= 1'b1;
            state      <= ST_UP;
          end else if (timer <= TW'(1)) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt   <= retry_cnt + RW'(1);
              connect_req <= 1'b1;
              state       <= ST_REQ;
            end else begin
              connect_fail <= 1'b1;
              state        <= ST_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_UP: begin
          // Link loss takes priority over a same-cycle disconnect request.
          if (!bus.connected_i) begin
            link_lost  <= 1'b1;
            session_up <= 1'b0;
            state      <= ST_IDLE;
          end else if (bus.disconnect_i) begin
            disconnect <= 1'b1;
            disc_host  <= addr;
            session_up <= 1'b0;
            state      <= ST_DISC;
          end
        end
        ST_DISC: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.connect_req_o         = connect_req;
  assign bus.connect_addr_o        = addr;
  assign bus.disconnect_o          = disconnect;
  assign bus.disconnect_host_num_o = disc_host;
  assign bus.session_up_o          = session_up;
  assign bus.connect_fail_o        = connect_fail;
  assign bus.link_lost_o           = link_lost;

  // ---------------------------------------------------------------- trailer framer
  // pos: 0 wait SOH, 1 '1', 2 '0', 3 '=', 4..6 digits, 7 closing SOH.
  logic [2:0] pos;
  logic [2:0] pos_nxt;
  logic       trailer_done;
  logic       accept;
  logic       is_soh;
  logic       is_digit;
  logic       msg_rcvd;
  logic       chk_err;

  assign accept   = bus.valid_i && (state == ST_UP);
  assign is_soh   = (bus.message_i == 8'h01);
  assign is_digit = (bus.message_i >= 8'h30) && (bus.message_i <= 8'h39);

  always_comb begin
    pos_nxt      = 3'd0;
    trailer_done = 1'b0;
    case (pos)
      3'd0: pos_nxt = is_soh ? 3'd1 : 3'd0;
      3'd1: pos_nxt = (bus.message_i == 8'h31) ? 3'd2 : (is_soh ? 3'd1 : 3'd0);
      3'd2: pos_nxt = (bus.message_i == 8'h30) ? 3'd3 : (is_soh ? 3'd1 : 3'd0);
      3'd3: pos_nxt = (bus.message_i == 8'h3d) ? 3'd4 : (is_soh ? 3'd1 : 3'd0);
      3'd4, 3'd5, 3'd6: pos_nxt = is_digit ? (pos + 3'd1) : (is_soh ? 3'd1 : 3'd0);
      3'd7: begin
        trailer_done = is_soh;
        pos_nxt      = 3'd0;
      end
      default: pos_nxt = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state != ST_UP)) begin
      pos <= 3'd0;
    end else if (accept) begin
      pos <= pos_nxt;
    end
  end

`ifdef FIX_CHECKSUM_EN
  logic [7:0] sum_all;  // running byte sum since message start
  logic [7:0] sum_soh;  // sum up to and including the SOH leading the current trailer candidate
  logic [9:0] cs_val;   // decimal value of the trailer digits
  logic [9:0] dig;

  assign dig = {2'b00, bus.message_i} - 10'h030;

  always_ff @(posedge clk) begin
    if (rst || (state != ST_UP)) begin
      sum_all  <= '0;
      sum_soh  <= '0;
      cs_val   <= '0;
      msg_rcvd <= 1'b0;
      chk_err  <= 1'b0;
    end else begin
      msg_rcvd <= 1'b0;
      chk_err  <= 1'b0;
      if (accept) begin
        sum_all <= trailer_done ? 8'h00 : (sum_all + bus.message_i);
        if (pos_nxt == 3'd1) begin
          sum_soh <= sum_all + bus.message_i;
        end
        if (pos == 3'd4 && is_digit) begin
          cs_val <= dig;
        end else if ((pos == 3'd5 || pos == 3'd6) && is_digit) begin
          cs_val <= (cs_val * 10'd10) + dig;
        end
        if (trailer_done) begin
          if ((cs_val <= 10'd255) && (cs_val[7:0] == sum_soh)) begin
            msg_rcvd <= 1'b1;
          end else begin
            chk_err <= 1'b1;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_rcvd <= 1'b0;
    end else begin
      msg_rcvd <= accept && trailer_done;
    end
  end

  assign chk_err = 1'b0;
`endif

  assign bus.message_received_o = msg_rcvd;
  assign bus.checksum_err_o     = chk_err;

endmodule
